// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS program loader: FSM states, error codes, HALT opcode.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CSUM  = 3'd2,
        ST_START = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_HALT = 2'd3;

    localparam logic [5:0] OP_HALT = 6'h3f;

endpackage

// File: rtl/mips_byte_packer.sv
// Packs accepted host bytes into 32-bit words; word_vld_o pulses the cycle after the 4th byte.
// flush_i discards a partially assembled word and any pending word pulse.
module mips_byte_packer #(
    parameter int BYTE_BE = 1
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_dat_i,
    output logic        word_vld_o,
    output logic [31:0] word_dat_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] sr_q, sr_d;
    logic [31:0] word_q, word_d;
    logic        vld_q, vld_d;
    logic [31:0] shifted;

    // Big-endian shifts bytes in from the bottom so the first byte ends in 31:24.
    assign shifted = (BYTE_BE != 0) ? {sr_q[23:0], byte_dat_i}
                                    : {byte_dat_i, sr_q[31:8]};

    always_comb begin
        cnt_d  = cnt_q;
        sr_d   = sr_q;
        word_d = word_q;
        vld_d  = 1'b0;
        if (flush_i) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (byte_vld_i) begin
            sr_d  = shifted;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                word_d = shifted;
                vld_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sr_q   <= '0;
            word_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
            word_q <= word_d;
            vld_q  <= vld_d;
        end
    end

    assign word_vld_o = vld_q;
    assign word_dat_o = word_q;

endmodule

// File: rtl/mips_prog_loader.sv
// Loads a length-prefixed, XOR-checksummed program into instruction memory, then starts
// the CPU and waits for HALTED. Header, address counter and checksum live here.
module mips_prog_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int BYTE_BE = 1
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              clear,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    input  logic              halted_i,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [31:0]         xor_q, xor_d;
    logic [1:0]          err_q, err_d;
    logic                stale_q, stale_d;

    logic                accept;
    logic                word_vld;
    logic [31:0]         word_dat;
    logic                len_ok;

    assign in_ready = !rst && (state_q == ST_HDR || state_q == ST_LOAD || state_q == ST_CSUM);
    assign accept   = in_valid && in_ready;

    mips_byte_packer #(.BYTE_BE(BYTE_BE)) u_packer (
        .clk1       (clk1),
        .rst        (rst),
        .flush_i    (clear),
        .byte_vld_i (accept),
        .byte_dat_i (in_data),
        .word_vld_o (word_vld),
        .word_dat_o (word_dat)
    );

    assign len_ok = (word_dat != '0) && ({1'b0, word_dat} <= DEPTH);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        xor_d   = xor_q;
        err_d   = err_q;
        stale_d = stale_q;
        if (clear) begin
            state_d = ST_HDR;
            idx_d   = '0;
            xor_d   = '0;
            err_d   = ERR_NONE;
            stale_d = 1'b0;
        end else begin
            case (state_q)
                ST_HDR: if (word_vld) begin
                    if (len_ok) begin
                        state_d = ST_LOAD;
                        // Last index is N-1; N = DEPTH truncates to 0 and wraps to all-ones.
                        last_d  = word_dat[ADDR_W-1:0] - ADDR_W'(1);
                    end else begin
                        state_d = ST_ERR;
                        err_d   = ERR_LEN;
                    end
                end
                ST_LOAD: if (word_vld) begin
                    xor_d = xor_q ^ word_dat;
                    if (idx_q == last_q) state_d = ST_CSUM;
                    else                 idx_d   = idx_q + ADDR_W'(1);
                end
                ST_CSUM: if (word_vld) begin
                    if (word_dat == xor_q) begin
                        state_d = ST_START;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = ERR_CSUM;
                    end
                end
                ST_START: begin
                    state_d = ST_RUN;
                    // HALTED seen at start belongs to the previous program run.
                    stale_d = halted_i;
                end
                ST_RUN: begin
                    if (halted_i && !stale_q) state_d = ST_DONE;
                    else if (!halted_i)       stale_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q <= ST_HDR;
            idx_q   <= '0;
            last_q  <= '0;
            xor_q   <= '0;
            err_q   <= ERR_NONE;
            stale_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            xor_q   <= xor_d;
            err_q   <= err_d;
            stale_q <= stale_d;
        end
    end

    assign mem_we    = (state_q == ST_LOAD) && word_vld && !clear;
    assign mem_addr  = idx_q;
    assign mem_wdata = word_dat;
    assign cpu_start = (state_q == ST_START);
    assign cpu_hold  = !(state_q == ST_START || state_q == ST_RUN);
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_CSUM) ||
                       (state_q == ST_START) || (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_ERR);
    assign err_code  = err_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Bench for mips_prog_loader: DUT A (ADDR_W=10, big-endian), DUT B (ADDR_W=2, little-endian).
module tb_mips_prog_loader;

    logic        clk1 = 1'b0;
    logic [1:0]  rst = 2'b11;
    logic [1:0]  in_valid = '0;
    logic [1:0]  clear = '0;
    logic [1:0]  halted = '0;
    logic [7:0]  in_data_a = '0, in_data_b = '0;
    wire  [1:0]  in_ready, mem_we, cpu_hold, cpu_start, busy, done, err;
    wire  [1:0]  ec_a, ec_b;
    wire  [9:0]  mem_addr_a;
    wire  [1:0]  mem_addr_b;
    wire  [31:0] mem_wdata_a, mem_wdata_b;

    int n_chk = 0, n_fail = 0, bad_we = 0;
    int starts[2];
    logic [63:0] wq_a[$], wq_b[$];

    always #5 clk1 = ~clk1;

    mips_prog_loader #(.ADDR_W(10), .BYTE_BE(1)) dut_a (
        .clk1(clk1), .rst(rst[0]), .in_valid(in_valid[0]), .in_data(in_data_a),
        .in_ready(in_ready[0]), .clear(clear[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .cpu_hold(cpu_hold[0]), .cpu_start(cpu_start[0]),
        .halted_i(halted[0]), .busy(busy[0]), .done(done[0]), .err(err[0]), .err_code(ec_a));

    mips_prog_loader #(.ADDR_W(2), .BYTE_BE(0)) dut_b (
        .clk1(clk1), .rst(rst[1]), .in_valid(in_valid[1]), .in_data(in_data_b),
        .in_ready(in_ready[1]), .clear(clear[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .cpu_hold(cpu_hold[1]), .cpu_start(cpu_start[1]),
        .halted_i(halted[1]), .busy(busy[1]), .done(done[1]), .err(err[1]), .err_code(ec_b));

    always @(negedge clk1) begin
        if (mem_we[0]) wq_a.push_back({32'(mem_addr_a), mem_wdata_a});
        if (mem_we[1]) wq_b.push_back({32'(mem_addr_b), mem_wdata_b});
        for (int i = 0; i < 2; i++) begin
            if (cpu_start[i]) starts[i]++;
            if (mem_we[i] && (err[i] || done[i] || !cpu_hold[i])) bad_we++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, required end before 500000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ec(input int sel);
        return (sel == 0) ? ec_a : ec_b;
    endfunction

    function automatic int wr_size(input int sel);
        return (sel == 0) ? wq_a.size() : wq_b.size();
    endfunction

    function automatic logic [63:0] wr_get(input int sel, input int i);
        return (sel == 0) ? wq_a[i] : wq_b[i];
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk1); #1; end
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b);
        int guard = 0;
        if ($urandom_range(0, 2) == 0) begin
            in_valid[sel] = 1'b0;
            cyc($urandom_range(1, 3));
        end
        in_valid[sel] = 1'b1;
        if (sel == 0) in_data_a = b; else in_data_b = b;
        while (!in_ready[sel] && guard < 30) begin cyc(1); guard++; end
        if (!in_ready[sel]) chk("ready_timeout", 64'(in_ready[sel]), 64'd1);
        cyc(1);
        in_valid[sel] = 1'b0;
    endtask

    // Byte order on the wire follows the endianness each DUT is built with.
    task automatic send_word(input int sel, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            if (sel == 0) send_byte(sel, w[31 - 8*k -: 8]);
            else          send_byte(sel, w[8*k +: 8]);
        end
    endtask

    task automatic chk_reset(input int sel, input string tag);
        chk({tag, "_rdy"},   64'(in_ready[sel]), 64'd0);
        chk({tag, "_we"},    64'(mem_we[sel]),   64'd0);
        chk({tag, "_addr"},  (sel == 0) ? 64'(mem_addr_a) : 64'(mem_addr_b), 64'd0);
        chk({tag, "_wdata"}, (sel == 0) ? 64'(mem_wdata_a) : 64'(mem_wdata_b), 64'd0);
        chk({tag, "_start"}, 64'(cpu_start[sel]), 64'd0);
        chk({tag, "_hold"},  64'(cpu_hold[sel]),  64'd1);
        chk({tag, "_stat"},  64'({busy[sel], done[sel], err[sel]}), 64'd0);
        chk({tag, "_ec"},    64'(ec(sel)), 64'd0);
    endtask

    // Reference: length must be in 1..2^aw, checksum is XOR of payload words only.
    task automatic run_case(input int sel, input string tag, input logic [31:0] hdr,
                            input logic [31:0] pl[$], input logic [31:0] csum);
        int       aw = (sel == 0) ? 10 : 2;
        bit       len_ok = (hdr != 0) && (64'(hdr) <= (64'd1 << aw));
        logic [31:0] x = '0;
        bit       ok;
        logic [1:0] exp_ec;
        foreach (pl[i]) x ^= pl[i];
        ok     = len_ok && (csum == x);
        exp_ec = !len_ok ? 2'd1 : (ok ? 2'd0 : 2'd2);
        if (sel == 0) wq_a.delete(); else wq_b.delete();
        starts[sel] = 0;
        send_word(sel, hdr);
        if (len_ok) begin
            foreach (pl[i]) send_word(sel, pl[i]);
            send_word(sel, csum);
        end
        cyc(6);
        chk({tag, "_nwr"}, 64'(wr_size(sel)), len_ok ? 64'(pl.size()) : 64'd0);
        for (int i = 0; i < wr_size(sel) && i < pl.size(); i++) begin
            chk($sformatf("%s_wr%0d", tag, i), wr_get(sel, i), {32'(i), pl[i]});
        end
        chk({tag, "_err"},   64'(err[sel]), 64'(!ok));
        chk({tag, "_ec"},    64'(ec(sel)), 64'(exp_ec));
        chk({tag, "_start"}, 64'(starts[sel]), ok ? 64'd1 : 64'd0);
        chk({tag, "_hold"},  64'(cpu_hold[sel]), 64'(!ok));
        chk({tag, "_busy"},  64'(busy[sel]), 64'(ok));
        chk({tag, "_rdy"},   64'(in_ready[sel]), 64'd0);
        if (ok) begin
            halted[sel] = 1'b1;
            cyc(1);
            chk({tag, "_done"},  64'(done[sel]), 64'd1);
            chk({tag, "_hold2"}, 64'(cpu_hold[sel]), 64'd1);
            halted[sel] = 1'b0;
        end
        clear[sel] = 1'b1;
        cyc(1);
        clear[sel] = 1'b0;
        chk({tag, "_clr_rdy"}, 64'(in_ready[sel]), 64'd1);
        chk({tag, "_clr_st"},  64'({busy[sel], done[sel], err[sel], ec(sel)}), 64'd0);
    endtask

    initial begin
        logic [31:0] pl[$];
        logic [31:0] x;
        int n;

        cyc(2);
        chk_reset(0, "rstA");
        chk_reset(1, "rstB");
        rst = 2'b00;
        cyc(1);
        chk("rdy_after_rst_a", 64'(in_ready[0]), 64'd1);
        chk("rdy_after_rst_b", 64'(in_ready[1]), 64'd1);

        // Example program; checksum computed from the XOR rule.
        pl.delete();
        pl.push_back(32'h2801000a); pl.push_back(32'h28020014); pl.push_back(32'hfc000000);
        x = '0; foreach (pl[i]) x ^= pl[i];
        run_case(0, "prog3", 32'd3, pl, x);

        pl.delete();
        run_case(0, "hdr0", 32'd0, pl, 32'd0);
        run_case(0, "hdr1025", 32'd1025 + $urandom_range(0, 500), pl, 32'd0);

        pl.delete(); pl.push_back(32'h00222000);
        run_case(0, "badsum", 32'd1, pl, 32'h00000000);

        for (int r = 0; r < 4; r++) begin
            pl.delete();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) pl.push_back($urandom);
            x = '0; foreach (pl[i]) x ^= pl[i];
            if (r == 3) x ^= 32'(1) << $urandom_range(0, 31);
            run_case(0, $sformatf("randA%0d", r), 32'(n), pl, x);
        end

        // Full-depth load on the 4-word DUT, then one word too many.
        pl.delete();
        for (int i = 0; i < 4; i++) pl.push_back($urandom);
        x = '0; foreach (pl[i]) x ^= pl[i];
        run_case(1, "fullB", 32'd4, pl, x);
        pl.delete();
        run_case(1, "hdr5B", 32'd5, pl, 32'd0);
        pl.delete(); pl.push_back($urandom); pl.push_back($urandom);
        x = pl[0] ^ pl[1];
        run_case(1, "randB", 32'd2, pl, x);

        // Reset after 6 bytes of a load, then a fresh one-word load.
        send_word(0, 32'd1);
        send_byte(0, 8'h12); send_byte(0, 8'h34);
        rst[0] = 1'b1;
        #1;
        chk_reset(0, "midrst");
        cyc(2);
        rst[0] = 1'b0;
        cyc(1);
        chk("midrst_rdy", 64'(in_ready[0]), 64'd1);
        pl.delete(); pl.push_back(32'hdeadbeef);
        run_case(0, "postrst", 32'd1, pl, 32'hdeadbeef);

        // Abort mid-load with clear; the partial word must be discarded.
        send_word(0, 32'd2);
        send_word(0, 32'h11111111);
        send_byte(0, 8'h55);
        clear[0] = 1'b1;
        cyc(1);
        clear[0] = 1'b0;
        pl.delete(); pl.push_back(32'h0badf00d);
        run_case(0, "postclr", 32'd1, pl, 32'h0badf00d);

        // Byte offered in the same cycle as clear is dropped.
        in_valid[0] = 1'b1; in_data_a = 8'hff; clear[0] = 1'b1;
        cyc(1);
        in_valid[0] = 1'b0; clear[0] = 1'b0;
        pl.delete(); pl.push_back(32'ha5a5a5a5);
        run_case(0, "clrbyte", 32'd1, pl, 32'ha5a5a5a5);

        // HALTED already high through START is stale until it falls and rises.
        starts[0] = 0;
        send_word(0, 32'd1);
        send_word(0, 32'h13572468);
        halted[0] = 1'b1;
        send_word(0, 32'h13572468);
        cyc(6);
        chk("stale_start", 64'(starts[0]), 64'd1);
        chk("stale_run",   64'({busy[0], done[0]}), 64'b10);
        halted[0] = 1'b0;
        cyc(2);
        chk("stale_low", 64'(done[0]), 64'd0);
        halted[0] = 1'b1;
        cyc(1);
        chk("stale_done", 64'(done[0]), 64'd1);
        halted[0] = 1'b0;
        clear[0] = 1'b1;
        cyc(1);
        clear[0] = 1'b0;

        chk("we_outside_load", 64'(bad_we), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
